// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth partial-product sequencer.
// The zero-digit skip feature is selected with the BOOTH_ZERO_SKIP_EN macro
// and is implemented entirely in booth_pp_sequencer.
package booth_pkg;

  // Radix-4 Booth digit values.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Sequencer states.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } seq_state_t;

  // 3-bit window {Y[2i+1], Y[2i], Y[2i-1]} -> digit, one 3-bit entry per
  // window value, entry 7 in the most significant position.
  localparam logic [23:0] BOOTH_DECODE_TABLE = {
    ZERO,  // 111
    NEG1,  // 110
    NEG1,  // 101
    NEG2,  // 100
    POS2,  // 011
    POS1,  // 010
    POS1,  // 001
    ZERO   // 000
  };

  // Number of radix-4 digits for an n-bit multiplier.
  function automatic int booth_num_digits(input int n);
    return n / 2;
  endfunction

  // Table lookup for one Booth window.
  function automatic booth_digit_t booth_decode(input logic [2:0] sel);
    logic [23:0] shifted;
    shifted = BOOTH_DECODE_TABLE >> (sel * 5'd3);
    return booth_digit_t'(shifted[2:0]);
  endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// Combinational radix-4 Booth digit encoder: one 3-bit multiplier window in,
// one signed digit out.
module booth_digit_encoder
  import booth_pkg::*;
(
  input  logic [2:0]   bits_i,
  output booth_digit_t digit_o
);

  // Decode the window through the shared table.
  always_comb begin
    digit_o = booth_decode(bits_i);
  end

endmodule

// File: rtl/booth_pp_sequencer.sv
// Sequential radix-4 Booth partial-product generator. Captures one signed
// operand pair, then emits one sign-extended, pre-shifted 2N-bit partial
// product per handshake; the beats sum (mod 2^2N) to the signed product.
// Define BOOTH_ZERO_SKIP_EN to suppress zero-valued digits.
module booth_pp_sequencer
  import booth_pkg::*;
#(
  parameter  int N          = 32,
  localparam int NUM_DIGITS = booth_num_digits(N),
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       multiplicand,
  input  logic [N-1:0]       multiplier,
  output logic               pp_valid,
  input  logic               pp_ready,
  output logic [2*N-1:0]     pp,
  output logic [IDX_W-1:0]   pp_idx,
  output logic               pp_last,
  output logic               busy
);

  localparam int PW = 2 * N;

  seq_state_t       state_q;
  logic [N-1:0]     x_q;
  logic [N:0]       y_q;          // {Y, 1'b0}: bit 0 is the implicit Y[-1]
  logic [IDX_W-1:0] idx_q;
  logic [PW-1:0]    pp_q;
  logic             pp_valid_q;
  logic             pp_last_q;
  logic             busy_q;

  logic             idle;
  logic [N-1:0]     x_src;
  logic [N:0]       y_src;
  logic [IDX_W-1:0] idx_d;
  logic             last_d;
  logic [2:0]       digit_bits;
  booth_digit_t     digit;
  logic [PW-1:0]    x_ext;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    signed_pp;
  logic [PW-1:0]    pp_d;

  assign idle = (state_q == S_IDLE);

  // At capture the next beat is built straight from the ports so digit 0
  // appears one cycle after the handshake; afterwards from the registers.
  always_comb begin
    x_src = idle ? multiplicand : x_q;
    y_src = idle ? {multiplier, 1'b0} : y_q;
  end

`ifdef BOOTH_ZERO_SKIP_EN
  logic [NUM_DIGITS-1:0] mask_q;
  logic [NUM_DIGITS-1:0] mask_live;
  logic [NUM_DIGITS-1:0] mask_src;
  logic [NUM_DIGITS-1:0] mask_above;

  // A digit is nonzero unless its three window bits are all equal.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_mask
    assign mask_live[gi] = !((y_src[2*gi+2] == y_src[2*gi+1]) &&
                             (y_src[2*gi+1] == y_src[2*gi]));
  end

  assign mask_src = idle ? mask_live : mask_q;

  // Jump to the lowest set mask bit above the current digit (or the lowest
  // overall at capture); an all-zero mask falls back to digit 0.
  always_comb begin
    idx_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask_src[i] && (idle || (i > int'(idx_q)))) begin
        idx_d = IDX_W'(i);
      end
    end
    mask_above = (mask_src >> idx_d) >> 1;
    last_d     = ~|mask_above;
  end
`else
  // Walk every digit in order; the top digit is the last beat.
  always_comb begin
    idx_d  = idle ? '0 : idx_q + 1'b1;
    last_d = (idx_d == IDX_W'(NUM_DIGITS - 1));
  end
`endif

  assign digit_bits = 3'(y_src >> {idx_d, 1'b0});

  booth_digit_encoder u_encoder (
    .bits_i  (digit_bits),
    .digit_o (digit)
  );

  // Scale, negate (full two's complement in 2N bits) and position the beat.
  always_comb begin
    x_ext = {{N{x_src[N-1]}}, x_src};
    case (digit)
      POS1, NEG1: mag = x_ext;
      POS2, NEG2: mag = x_ext << 1;
      default:    mag = '0;
    endcase
    signed_pp = ((digit == NEG1) || (digit == NEG2)) ? (~mag + 1'b1) : mag;
    pp_d      = signed_pp << {idx_d, 1'b0};
  end

  // Sequencer FSM: capture in IDLE, issue one beat per handshake in ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      pp_q       <= '0;
      pp_valid_q <= 1'b0;
      pp_last_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BOOTH_ZERO_SKIP_EN
      mask_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q        <= multiplicand;
            y_q        <= {multiplier, 1'b0};
`ifdef BOOTH_ZERO_SKIP_EN
            mask_q     <= mask_live;
`endif
            pp_q       <= pp_d;
            idx_q      <= idx_d;
            pp_last_q  <= last_d;
            pp_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (pp_ready) begin
            if (pp_last_q) begin
              pp_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              pp_q      <= pp_d;
              idx_q     <= idx_d;
              pp_last_q <= last_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = rst_n && idle;
  assign pp_valid = pp_valid_q;
  assign pp       = pp_q;
  assign pp_idx   = idx_q;
  assign pp_last  = pp_last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_booth_pp_sequencer.sv
// Directed and randomized bench for booth_pp_sequencer (N=32). Honours the
// BOOTH_ZERO_SKIP_EN macro for build-specific beat expectations.
module tb_booth_pp_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        pp_valid;
  logic        pp_ready;
  logic [63:0] pp;
  logic [3:0]  pp_idx;
  logic        pp_last;
  logic        busy;

  int checks;
  int failures;

  logic [63:0] b_pp[$];
  int          b_idx[$];
  logic [63:0] sum;

  booth_pp_sequencer #(.N(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .pp_valid     (pp_valid),
    .pp_ready     (pp_ready),
    .pp           (pp),
    .pp_idx       (pp_idx),
    .pp_last      (pp_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: pp_ready high; 1: random; 2: random + 10-cycle hold on idx1 +
  // in_valid pulses while busy.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input int mode, input string tag);
    logic [63:0] prev_pp;
    logic [3:0]  prev_idx;
    logic        prev_last;
    bit          stalled;
    bit          done;
    bit          r;
    int          hold;
    b_pp.delete();
    b_idx.delete();
    sum = '0; stalled = 0; done = 0; hold = 0;
    prev_pp = '0; prev_idx = '0; prev_last = 1'b0;
    @(negedge clk);
    multiplicand = x; multiplier = y; in_valid = 1'b1; pp_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s in_ready_idle got=%b want=1", tag, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    checks++;
    if (pp_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s latency1 got valid=%b busy=%b in_ready=%b want 1/1/0",
               tag, pp_valid, busy, in_ready);
    end
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (stalled) begin
        checks++;
        if (pp_valid !== 1'b1 || pp !== prev_pp || pp_idx !== prev_idx ||
            pp_last !== prev_last) begin
          failures++;
          $display("FAIL %s stall_stable got v=%b pp=%h idx=%0d last=%b want v=1 pp=%h idx=%0d last=%b",
                   tag, pp_valid, pp, pp_idx, pp_last, prev_pp, prev_idx, prev_last);
        end
      end
      if (pp_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s valid_dropped got=%b want=1", tag, pp_valid);
        break;
      end
      if (mode == 2 && cyc < 2) begin
        in_valid = 1'b1; multiplicand = 32'h0000_0063; multiplier = 32'h0000_0063;
      end else begin
        in_valid = 1'b0;
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 2 && pp_idx == 4'd1 && hold < 10) begin
        r = 1'b0; hold++;
      end else r = ($urandom_range(0, 3) != 0);
      pp_ready = r;
      if (r) begin
        b_pp.push_back(pp);
        b_idx.push_back(int'(pp_idx));
        sum = sum + pp;
        if (pp_last) done = 1;
      end
      stalled = !r;
      prev_pp = pp; prev_idx = pp_idx; prev_last = pp_last;
      @(negedge clk);
    end
    in_valid = 1'b0; pp_ready = 1'b0;
    checks++;
    if (!done) begin
      failures++; $display("FAIL %s timeout got=no_last want=last_beat", tag);
    end
    checks++;
    if (pp_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end_state got v=%b in_ready=%b busy=%b want 0/1/0",
               tag, pp_valid, in_ready, busy);
    end
    $display("op %s x=%h y=%h beats=%0d sum=%h", tag, x, y, b_pp.size(), sum);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; pp_ready = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pp_valid !== 1'b0 || pp !== 64'd0 || pp_idx !== 4'd0 ||
        pp_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got v=%b pp=%h idx=%0d last=%b busy=%b in_ready=%b want all 0",
               pp_valid, pp, pp_idx, pp_last, busy, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_basic();
    run_op(32'd7, 32'hFFFF_FFFD, 0, "x7_ym3");
    checks++;
    if (sum !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failures++; $display("FAIL x7_ym3 sum got=%h want=%h", sum, 64'hFFFF_FFFF_FFFF_FFEB);
    end
`ifdef BOOTH_ZERO_SKIP_EN
    checks++;
    if (b_pp.size() != 2) begin
      failures++; $display("FAIL x7_ym3 beats got=%0d want=2", b_pp.size());
    end else begin
      checks++;
      if (b_idx[0] != 0 || b_idx[1] != 1 || b_pp[0] !== 64'd7 ||
          b_pp[1] !== 64'hFFFF_FFFF_FFFF_FFE4) begin
        failures++;
        $display("FAIL x7_ym3 beat_vals got idx=%0d,%0d pp=%h,%h want idx=0,1 pp=7,ffffffffffffffe4",
                 b_idx[0], b_idx[1], b_pp[0], b_pp[1]);
      end
    end
`else
    checks++;
    if (b_pp.size() != 16) begin
      failures++; $display("FAIL x7_ym3 beats got=%0d want=16", b_pp.size());
    end else begin
      checks++;
      if (b_pp[0] !== 64'd7 || b_pp[1] !== 64'hFFFF_FFFF_FFFF_FFE4) begin
        failures++;
        $display("FAIL x7_ym3 low_beats got=%h,%h want=7,ffffffffffffffe4", b_pp[0], b_pp[1]);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (b_idx[i] != i || (i >= 2 && b_pp[i] !== 64'd0)) begin
          failures++;
          $display("FAIL x7_ym3 beat%0d got idx=%0d pp=%h want idx=%0d pp=0(if>=2)",
                   i, b_idx[i], b_pp[i], i);
        end
      end
    end
`endif
  endtask

  task automatic test_min_operands();
    run_op(32'h8000_0000, 32'h8000_0000, 0, "min_min");
    checks++;
    if (sum !== 64'h4000_0000_0000_0000) begin
      failures++; $display("FAIL min_min sum got=%h want=4000000000000000", sum);
    end
`ifdef BOOTH_ZERO_SKIP_EN
    checks++;
    if (b_pp.size() != 1 || b_idx[0] != 15 || b_pp[0] !== 64'h4000_0000_0000_0000) begin
      failures++;
      $display("FAIL min_min single_beat got beats=%0d idx=%0d pp=%h want 1/15/4000000000000000",
               b_pp.size(), b_idx.size() > 0 ? b_idx[0] : -1, b_pp.size() > 0 ? b_pp[0] : 64'd0);
    end
`else
    checks++;
    if (b_pp.size() != 16 || b_idx[15] != 15 || b_pp[15] !== 64'h4000_0000_0000_0000) begin
      failures++;
      $display("FAIL min_min idx15 got beats=%0d want 16 with idx15 pp=4000000000000000",
               b_pp.size());
    end
`endif
  endtask

  task automatic test_zero_multiplier();
    run_op(32'h0000_1234, 32'd0, 0, "y_zero");
    checks++;
    if (sum !== 64'd0) begin
      failures++; $display("FAIL y_zero sum got=%h want=0", sum);
    end
`ifdef BOOTH_ZERO_SKIP_EN
    checks++;
    if (b_pp.size() != 1 || b_idx[0] != 0 || b_pp[0] !== 64'd0) begin
      failures++;
      $display("FAIL y_zero single_beat got beats=%0d want 1 beat idx0 pp0", b_pp.size());
    end
`else
    checks++;
    if (b_pp.size() != 16) begin
      failures++; $display("FAIL y_zero beats got=%0d want=16", b_pp.size());
    end
`endif
  endtask

  task automatic test_backpressure();
    run_op(32'd5, 32'd6, 2, "bp_5x6");
    checks++;
    if (sum !== 64'd30) begin
      failures++; $display("FAIL bp_5x6 sum got=%0d want=30", sum);
    end
`ifdef BOOTH_ZERO_SKIP_EN
    checks++;
    if (b_pp.size() != 2) begin
      failures++; $display("FAIL bp_5x6 beats got=%0d want=2", b_pp.size());
    end
`else
    checks++;
    if (b_pp.size() != 16) begin
      failures++; $display("FAIL bp_5x6 beats got=%0d want=16", b_pp.size());
    end
`endif
  endtask

  task automatic test_reset_midop();
    bit hit;
    hit = 0;
    @(negedge clk);
    multiplicand = 32'd3; multiplier = 32'h5555_5555; in_valid = 1'b1; pp_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (pp_valid === 1'b1 && pp_idx === 4'd3) hit = 1;
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL midop reach_idx3 got=not_reached want=idx3");
    end
    pp_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (pp_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midop after_reset got v=%b busy=%b in_ready=%b want 0/0/0",
               pp_valid, busy, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL midop ready_after_release got=%b want=1", in_ready);
    end
    pp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (pp_valid !== 1'b0) begin
        failures++; $display("FAIL midop stale_beat got=%b want=0", pp_valid);
      end
    end
    pp_ready = 1'b0;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "m1_m1");
    checks++;
    if (sum !== 64'd1) begin
      failures++; $display("FAIL m1_m1 sum got=%h want=1", sum);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    longint      gold;
    bit          order_ok;
    for (int n = 0; n < 1000; n++) begin
      x = $urandom; y = $urandom;
      if (n == 0) x = 32'h8000_0000;
      if (n == 1) y = 32'h8000_0000;
      gold = longint'($signed(x)) * longint'($signed(y));
      run_op(x, y, 1, "rand");
      checks++;
      if (sum !== 64'(gold)) begin
        failures++; $display("FAIL rand_sum x=%h y=%h got=%h want=%h", x, y, sum, 64'(gold));
      end
      order_ok = (b_pp.size() >= 1);
      for (int i = 1; i < b_idx.size(); i++) if (b_idx[i] <= b_idx[i-1]) order_ok = 0;
`ifndef BOOTH_ZERO_SKIP_EN
      if (b_pp.size() != 16) order_ok = 0;
`endif
      checks++;
      if (!order_ok) begin
        failures++; $display("FAIL rand_order x=%h y=%h got beats=%0d want ordered beats", x, y, b_pp.size());
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_min_operands();
    test_zero_multiplier();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
